array_feeder: RTL and testbench
===============================

// Module: array_feeder
// PURPOSE
//   Input sequencer sitting directly upstream of the sum/difference PE array.
//   - Accepts a valid/ready sample stream and buffers it in whole blocks of BLOCK_LEN samples.
//   - Replays each full block to the array as one contiguous burst.
//   - Generates the array control per sample: x, sum_diff_sel (alternates 0,1,...) and load
//     (high on the first two samples of a block).
//   - Ping-pong buffering lets the upstream keep writing one bank while the other is issued.
// PARAMETERS
//   DATA_WIDTH  8   sample width in bits; matches the array x/z width
//   BLOCK_LEN   8   samples per block; power of two, >= 2
// PORTS
//   clk           in   1           single clock, rising edge
//   rst           in   1           asynchronous, active-high reset
//   in_data       in   DATA_WIDTH  input sample
//   in_valid      in   1           in_data valid
//   in_last       in   1           marks the final sample of a short (partial) block; qualified by in_valid
//   in_ready      out  1           feeder can accept a sample this cycle
//   issue_en      in   1           array step enable; 0 stalls issue
//   x             out  DATA_WIDTH  sample to array
//   sum_diff_sel  out  1           0 = sum, 1 = difference
//   load          out  1           array load strobe
//   out_valid     out  1           x / sum_diff_sel / load are meaningful
// BEHAVIOUR
//   Reset (async, immediate)
//   - x=0, sum_diff_sel=0, load=0, out_valid=0.
//   - Both banks are marked empty, write/read pointers=0, write bank=0, read bank=0.
//   - in_ready=1 from the first cycle after reset deasserts.
//   Write side
//   - A sample is accepted on a rising edge with in_valid & in_ready.
//   - Accepted samples go to wbank[wptr]; wptr increments.
//   - On wptr==BLOCK_LEN-1, or on in_last: mark the bank full, wptr->0, toggle the write bank.
//   - in_last at index k<BLOCK_LEN-1: remaining entries k+1..BLOCK_LEN-1 read as 0 (zero padding).
//     No extra input cycles are consumed.
//   - in_ready = !full[write bank] (combinational from registered flags).
//   Read side, FSM
//   - IDLE -> ISSUE when full[read bank] is set, evaluated at the edge.
//   - ISSUE, with issue_en=1 at an edge:
//     - Registered outputs take x=rbank[ridx], sum_diff_sel=ridx[0], load=(ridx<2), out_valid=1.
//     - ridx increments.
//   - ISSUE, with issue_en=0 at an edge: out_valid=0, load=0, sum_diff_sel=0, x=0; ridx holds.
//   - After ridx==BLOCK_LEN-1 is issued: clear full[read bank], toggle the read bank, ridx->0.
//     - Next state is ISSUE if the other bank is already full (back-to-back, no bubble).
//     - Otherwise the next state is IDLE.
//   - Outside valid issue cycles: x=0, sum_diff_sel=0, load=0.
//   Latency
//   - Block completes (last write, or in_last) at edge k.
//   - Earliest first x of that block is at out_valid after edge k+1, assuming reader IDLE and issue_en=1.
//   Boundary conditions
//   - Same-cycle write-complete and read-complete on different banks: both take effect.
//     in_ready stays 1 if the freed bank is the next write bank.
//   - Write and read never target the same bank while it is full.
//   - Both banks full: in_ready=0 until the reader frees one.
//   - Reset mid-block: outputs drop in the same cycle, the partial block is discarded,
//     and no stale samples are emitted afterwards.
//   Arithmetic
//   - No arithmetic on data; samples pass unmodified.
//   - Pointers are $clog2(BLOCK_LEN) bits; wrap is explicit, not relied on via overflow.
// STRUCTURE
//   - array_pkg holds:
//     - DATA_WIDTH and BLOCK_LEN defaults
//     - typedef logic [DATA_WIDTH-1:0] data_t
//     - typedef enum {IDLE, ISSUE} feeder_state_e
//     - localparam IDX_W = $clog2(BLOCK_LEN)
//   - Sub-module pingpong_bank: two BLOCK_LEN x DATA_WIDTH register banks, full flags,
//     write pointer and zero-pad on short block.
//   - array_feeder adds the read FSM and the output registers.
// TESTING  (BLOCK_LEN=8 unless noted)
//   1. Reset: hold rst 3 cycles -> all outputs 0, in_ready=1 after release; no out_valid for 20 idle cycles.
//   2. Single block: push 0..7 with issue_en=1 ->
//      - out_valid for exactly 8 consecutive cycles starting one edge after sample 7 is accepted
//      - x=0..7, sum_diff_sel=0,1,0,1,0,1,0,1, load=1,1,0,0,0,0,0,0
//   3. Back-to-back: push 0..15 continuously -> 16 consecutive out_valid, x=0..15, load high at x=0,1,8,9 only.
//   4. Backpressure: issue_en=0, offer 20 samples ->
//      - exactly 16 accepted, in_ready=0 afterwards
//      - with issue_en=1, x=0..15 appear in order; in_ready rises after x=7 is issued
//   5. Short block: push 10,11,12,13,14 with in_last on 14 -> x=10,11,12,13,14,0,0,0, load on 10,11.
//   6. Mid-issue reset: assert rst while x=3 is on the output ->
//      - out_valid=0 immediately
//      - after release, in_ready=1; the next block pushed issues alone with correct load/sel pattern

Source files
------------

// File: rtl/array_pkg.sv
// Shared types and defaults for the PE-array input feeder.
package array_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_BLOCK_LEN  = 8;
  localparam int unsigned IDX_W          = $clog2(DEF_BLOCK_LEN);

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

  typedef enum logic [0:0] {
    IDLE,
    ISSUE
  } feeder_state_e;

  // The array latches its operands on the first two samples of every block.
  function automatic logic is_load_slot(input int unsigned idx);
    return idx < 32'd2;
  endfunction

endpackage

// File: rtl/array_feeder_if.sv
// Sample stream in, array control out. The feeder takes the slave view.
interface array_feeder_if #(
  parameter int unsigned DATA_WIDTH = array_pkg::DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  issue_en;
  logic [DATA_WIDTH-1:0] x;
  logic                  sum_diff_sel;
  logic                  load;
  logic                  out_valid;

  modport master (
    output in_data, in_valid, in_last, issue_en,
    input  in_ready, x, sum_diff_sel, load, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, issue_en,
    output in_ready, x, sum_diff_sel, load, out_valid
  );

endinterface

// File: rtl/array_feeder_pingpong_bank.sv
// Two register banks of BLOCK_LEN samples with full flags. The writer fills one bank
// while the reader drains the other; a short block is zero-padded on its last write.
module pingpong_bank
  import array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BLOCK_LEN  = DEF_BLOCK_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         wr_valid,
  input  logic                         wr_last,
  output logic                         wr_ready,
  output logic                         wr_done,
  output logic                         wr_bank,
  input  logic                         rd_bank,
  input  logic [$clog2(BLOCK_LEN)-1:0] rd_idx,
  input  logic                         rd_release,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [1:0]                   full
);

  localparam int unsigned     IdxW    = $clog2(BLOCK_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_LEN - 1);

  logic [1:0]            full_q, full_d;
  logic                  wbank_q;
  logic [IdxW-1:0]       wptr_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_view [2][BLOCK_LEN];

  assign wr_ready = ~full_q[wbank_q];
  assign accept   = wr_valid & wr_ready;
  assign wr_done  = accept & ((wptr_q == LastIdx) | wr_last);
  assign wr_bank  = wbank_q;
  assign full     = full_q;
  assign rd_data  = rd_view[rd_bank][rd_idx];

  // Next full flags: the reader frees its bank, the writer seals its own. They never
  // coincide on one bank because the writer only ever points at an empty bank.
  always_comb begin
    full_d = full_q;
    if (rd_release) begin
      full_d[rd_bank] = 1'b0;
    end
    if (wr_done) begin
      full_d[wbank_q] = 1'b1;
    end
  end

  // Write pointer, active write bank and full flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      wptr_q  <= '0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        if (wr_done) begin
          wptr_q  <= '0;
          wbank_q <= ~wbank_q;
        end else begin
          wptr_q <= wptr_q + IdxW'(1);
        end
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar i = 0; i < BLOCK_LEN; i++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_q;
      logic                  sel_bank;

      assign sel_bank       = accept & (wbank_q == 1'(b));
      assign rd_view[b][i]  = entry_q;

      // Store the sample at the write pointer; on in_last clear everything above it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= '0;
        end else if (sel_bank) begin
          if (wptr_q == IdxW'(i)) begin
            entry_q <= wr_data;
          end else if (wr_last && (IdxW'(i) > wptr_q)) begin
            entry_q <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/array_feeder.sv
// Buffers the sample stream into ping-pong blocks and replays each full block to the
// sum/difference PE array as one burst with registered x / sum_diff_sel / load.
module array_feeder
  import array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BLOCK_LEN  = DEF_BLOCK_LEN
) (
  input logic           clk,
  input logic           rst,
  array_feeder_if.slave bus
);

  localparam int unsigned     IdxW    = $clog2(BLOCK_LEN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_LEN - 1);

  feeder_state_e         state_q, state_d;
  logic                  rbank_q, rbank_d;
  logic [IdxW-1:0]       ridx_q, ridx_d;
  logic                  rd_release;
  logic                  issue_fire;

  logic                  wr_ready;
  logic                  wr_done;
  logic                  wr_bank;
  logic [1:0]            full;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  cur_full;
  logic                  other_full;

  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic                  sel_q, sel_d;
  logic                  load_q, load_d;
  logic                  valid_q, valid_d;

  pingpong_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_LEN  (BLOCK_LEN)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (bus.in_data),
    .wr_valid   (bus.in_valid),
    .wr_last    (bus.in_last),
    .wr_ready   (wr_ready),
    .wr_done    (wr_done),
    .wr_bank    (wr_bank),
    .rd_bank    (rbank_q),
    .rd_idx     (ridx_q),
    .rd_release (rd_release),
    .rd_data    (rd_data),
    .full       (full)
  );

  assign bus.in_ready = wr_ready;

  // Bank full as of the coming edge, including a block the writer seals this cycle.
  // This is what lets the first sample go out one edge after the block completes and
  // lets a burst roll straight into the other bank without a bubble.
  assign cur_full   = full[rbank_q] | (wr_done & (wr_bank == rbank_q));
  assign other_full = full[~rbank_q] | (wr_done & (wr_bank != rbank_q));

  // Read FSM state, read bank and read index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rbank_q <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      rbank_q <= rbank_d;
      ridx_q  <= ridx_d;
    end
  end

  // Next state: wait for a full bank, then step through it while issue_en is high.
  always_comb begin
    state_d    = state_q;
    rbank_d    = rbank_q;
    ridx_d     = ridx_q;
    rd_release = 1'b0;
    issue_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cur_full) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.issue_en) begin
          issue_fire = 1'b1;
          if (ridx_q == LastIdx) begin
            rd_release = 1'b1;
            rbank_d    = ~rbank_q;
            ridx_d     = '0;
            state_d    = other_full ? ISSUE : IDLE;
          end else begin
            ridx_d = ridx_q + IdxW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array control for the sample being issued; all zero on idle and stalled cycles.
  always_comb begin
    x_d     = '0;
    sel_d   = 1'b0;
    load_d  = 1'b0;
    valid_d = 1'b0;
    if (issue_fire) begin
      x_d     = rd_data;
      sel_d   = ridx_q[0];
      load_d  = is_load_slot(32'(ridx_q));
      valid_d = 1'b1;
    end
  end

  // Output registers; reset clears them immediately so nothing stale reaches the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      sel_q   <= 1'b0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      valid_q <= valid_d;
    end
  end

  assign bus.x            = x_q;
  assign bus.sum_diff_sel = sel_q;
  assign bus.load         = load_q;
  assign bus.out_valid    = valid_q;

endmodule

// File: tb/tb_array_feeder.sv
// Directed bench for array_feeder with BLOCK_LEN = 8, DATA_WIDTH = 8.
module tb_array_feeder;
  import array_pkg::*;

  typedef struct {
    logic       drive;
    logic [7:0] din;
    logic       last;
    logic [7:0] ex;
    logic       es;
    logic       el;
  } vec_t;

  typedef struct {
    data_t x;
    logic  sel;
    logic  load;
    int    cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_feeder_if #(.DATA_WIDTH(8)) bus ();

  array_feeder #(
    .DATA_WIDTH (8),
    .BLOCK_LEN  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc = 0;
  obs_t obs[$];
  vec_t tbl[$];
  vec_t t_single[8];
  vec_t t_short[8];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_acc;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every issued sample with the edge count it appeared after.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) obs.push_back('{bus.x, bus.sum_diff_sel, bus.load, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Offer one sample and return the edge count at which it was accepted.
  task automatic push(input logic [7:0] d, input logic l, output int acc_cyc);
    logic rdy;
    int   t;
    t            = 0;
    acc_cyc      = -1;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    while (acc_cyc < 0 && t < 200) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) acc_cyc = cyc;
      t++;
    end
    if (acc_cyc < 0) timeout("push");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic apply_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].drive) push(tbl[i].din, tbl[i].last, last_acc);
    end
  endtask

  task automatic wait_obs(input int n, input string tag);
    int t;
    t = 0;
    while (obs.size() < n && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (obs.size() < n) timeout({tag, "_wait"});
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_tbl(input string tag);
    check({tag, "_count"}, obs.size(), tbl.size());
    for (int i = 0; i < tbl.size() && i < obs.size(); i++) begin
      check($sformatf("%s[%0d].x", tag, i), 32'(obs[i].x), 32'(tbl[i].ex));
      check($sformatf("%s[%0d].sel", tag, i), 32'(obs[i].sel), 32'(tbl[i].es));
      check($sformatf("%s[%0d].load", tag, i), 32'(obs[i].load), 32'(tbl[i].el));
      if (i > 0) check($sformatf("%s[%0d].gap", tag, i), obs[i].cyc, obs[0].cyc + i);
    end
  endtask

  task automatic check_latency(input string tag);
    if (obs.size() > 0) check({tag, "_latency"}, obs[0].cyc, last_acc + 1);
  endtask

  initial begin
    logic rdy;
    int   n_acc;
    int   ready_cyc;
    int   t;
    logic found;

    //                  drive  din    last  ex     sel   load
    t_single[0] = '{1'b1, 8'd0,  1'b0, 8'd0,  1'b0, 1'b1};
    t_single[1] = '{1'b1, 8'd1,  1'b0, 8'd1,  1'b1, 1'b1};
    t_single[2] = '{1'b1, 8'd2,  1'b0, 8'd2,  1'b0, 1'b0};
    t_single[3] = '{1'b1, 8'd3,  1'b0, 8'd3,  1'b1, 1'b0};
    t_single[4] = '{1'b1, 8'd4,  1'b0, 8'd4,  1'b0, 1'b0};
    t_single[5] = '{1'b1, 8'd5,  1'b0, 8'd5,  1'b1, 1'b0};
    t_single[6] = '{1'b1, 8'd6,  1'b0, 8'd6,  1'b0, 1'b0};
    t_single[7] = '{1'b1, 8'd7,  1'b0, 8'd7,  1'b1, 1'b0};

    t_short[0]  = '{1'b1, 8'd10, 1'b0, 8'd10, 1'b0, 1'b1};
    t_short[1]  = '{1'b1, 8'd11, 1'b0, 8'd11, 1'b1, 1'b1};
    t_short[2]  = '{1'b1, 8'd12, 1'b0, 8'd12, 1'b0, 1'b0};
    t_short[3]  = '{1'b1, 8'd13, 1'b0, 8'd13, 1'b1, 1'b0};
    t_short[4]  = '{1'b1, 8'd14, 1'b1, 8'd14, 1'b0, 1'b0};
    t_short[5]  = '{1'b0, 8'd0,  1'b0, 8'd0,  1'b1, 1'b0};
    t_short[6]  = '{1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0};
    t_short[7]  = '{1'b0, 8'd0,  1'b0, 8'd0,  1'b1, 1'b0};

    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.issue_en = 1'b0;

    // 1. Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_sel", 32'(bus.sum_diff_sel), 32'd0);
    check("rst_load", 32'(bus.load), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.issue_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_no_valid", obs.size(), 32'd0);

    // 2. Single block
    obs.delete();
    tbl.delete();
    foreach (t_single[i]) tbl.push_back(t_single[i]);
    apply_tbl();
    wait_obs(8, "single");
    check_tbl("single");
    check_latency("single");

    // 3. Back-to-back blocks
    obs.delete();
    tbl.delete();
    for (int i = 0; i < 16; i++) begin
      tbl.push_back('{1'b1, 8'(i), 1'b0, 8'(i), 1'(i % 2), (i == 0 || i == 1 || i == 8 || i == 9)});
    end
    apply_tbl();
    wait_obs(16, "b2b");
    check_tbl("b2b");

    // 4. Backpressure: both banks fill while issue is stalled
    obs.delete();
    bus.issue_en = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 24; c++) begin
      bus.in_data  = 8'(n_acc);
      bus.in_valid = 1'b1;
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) n_acc++;
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", n_acc, 32'd16);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_no_valid", obs.size(), 32'd0);
    bus.issue_en = 1'b1;
    ready_cyc = -1;
    t = 0;
    while (obs.size() < 16 && t < 100) begin
      @(negedge clk);
      if (ready_cyc < 0 && bus.in_ready === 1'b1) ready_cyc = cyc;
      t++;
    end
    if (obs.size() < 16) timeout("bp_wait");
    repeat (4) @(posedge clk);
    #1;
    check_tbl("bp");
    if (obs.size() > 7) check("bp_ready_rise", ready_cyc, obs[7].cyc);

    // 5. Short block with zero padding
    obs.delete();
    tbl.delete();
    foreach (t_short[i]) tbl.push_back(t_short[i]);
    apply_tbl();
    wait_obs(8, "short");
    check_tbl("short");
    check_latency("short");

    // 6. Reset while x=3 is on the output
    obs.delete();
    tbl.delete();
    foreach (t_single[i]) tbl.push_back(t_single[i]);
    apply_tbl();
    found = 1'b0;
    t = 0;
    while (!found && t < 50) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.x === 8'd3) found = 1'b1;
      t++;
    end
    if (!found) timeout("mid_rst_find_x3");
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_x", 32'(bus.x), 32'd0);
    check("mid_rst_load", 32'(bus.load), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    obs.delete();
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_no_stale", obs.size(), 32'd0);
    tbl.delete();
    for (int i = 0; i < 8; i++) begin
      tbl.push_back('{1'b1, 8'(40 + i), 1'b0, 8'(40 + i), t_single[i].es, t_single[i].el});
    end
    apply_tbl();
    wait_obs(8, "post_rst");
    check_tbl("post_rst");
    check_latency("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
